// File: rtl/ifu_if.sv
// Instruction fetch bus: imem request/response plus core-side instruction hand-off.
// master = ifu side, slave = memory/core side.
interface ifu_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        inst_ready;
  logic        jump;
  logic        pcsrc;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc, op, funct,
    input  inst_ready, jump, pcsrc,
    input  jump_target, branch_target,
    output fault
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc, op, funct,
    output inst_ready, jump, pcsrc,
    output jump_target, branch_target,
    input  fault
  );
endinterface

// File: rtl/ifu.sv
// Multi-cycle fetch unit: one outstanding imem read, buffered inst, next-PC select.
// Ports: clk, rst_n (async low), bus (ifu_if.master).
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic clk,
  input  logic rst_n,
  ifu_if.master bus
);

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_q, inst_n;
  logic [31:0] ipc_q, ipc_n;
  logic [31:0] nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      inst_q <= '0;
      ipc_q  <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      inst_q <= inst_n;
      ipc_q  <= ipc_n;
    end
  end

  always_comb begin
    if (bus.jump)
      nxt = bus.jump_target;
    else if (bus.pcsrc)
      nxt = bus.branch_target;
    else
      nxt = pc + 32'd4;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    inst_n  = inst_q;
    ipc_n   = ipc_q;
    unique case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (bus.imem_req_ready)
          state_n = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          inst_n  = bus.imem_resp_data;
          ipc_n   = pc;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          // a misaligned target parks the unit; pc keeps the faulting inst's pc
          if (nxt[1:0] == 2'b00) begin
            pc_n    = nxt;
            state_n = REQ;
          end else begin
            state_n = FAULT;
          end
        end
      end
      FAULT: state_n = FAULT;
      default: state_n = BOOT;
    endcase
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state == HOLD);
  assign bus.fault          = (state == FAULT);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = ipc_q;
  assign bus.op             = inst_q[31:26];
  assign bus.funct          = inst_q[5:0];

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle MIPS core. Holds the PC and issues one instruction-memory read at a time over a valid/ready request and response interface. It buffers the returned word and presents it, with `op`/`funct` slices, to the main controller and datapath. On retirement it selects the next PC from the controller's `jump`/`pcsrc` decisions and the datapath targets.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC fetched first after reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: read request to instruction memory.
- `imem_req_addr` out 32: request address, equal to the current PC.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_resp_valid` in 1: read data valid this cycle.
- `imem_resp_data` in 32: read data.
- `inst_valid` out 1: buffered instruction is available.
- `inst` out 32: buffered instruction word.
- `inst_pc` out 32: PC of `inst`.
- `op` out 6: `inst[31:26]`, to the controller.
- `funct` out 6: `inst[5:0]`, to the controller.
- `inst_ready` in 1: core retires `inst` this cycle.
- `jump` in 1: from the controller; sampled only at retire.
- `pcsrc` in 1: from the controller; sampled only at retire.
- `jump_target` in 32: sampled only at retire.
- `branch_target` in 32: sampled only at retire.
- `fault` out 1: sticky misaligned-next-PC fault.

## Operation
- FSM states: BOOT, REQ, WAIT, HOLD, FAULT.
- Reset state is BOOT. Internal `pc` = RESET_PC.
- BOOT -> REQ unconditionally.
- REQ:
  - `imem_req_valid`=1 and `imem_req_addr`=`pc`.
  - `imem_req_ready`=1 -> WAIT.
  - `imem_resp_valid` is ignored.
- WAIT:
  - `imem_resp_valid`=1 -> capture `inst`=`imem_resp_data` and `inst_pc`=`pc`, then go to HOLD.
  - Only one request is ever outstanding.
- HOLD:
  - `inst_valid`=1.
  - `inst` and `inst_pc` stay stable until retire.
  - Retire is `inst_ready`=1. At retire, compute `next` with this priority:
    - `jump` -> `jump_target`
    - else `pcsrc` -> `branch_target`
    - else `pc`+4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
  - If `next[1:0]`==0: `pc`<=`next`, go to REQ.
  - Otherwise: `fault`<=1, `pc` unchanged, go to FAULT.
- FAULT is terminal until reset: no requests are issued, `inst_valid`=0, `fault`=1.
- `op` and `funct` are combinational slices of the `inst` register.
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `op`=0, `funct`=0, `fault`=0.
- Reset asserted mid-transaction (REQ, WAIT or HOLD) returns to BOOT immediately. Any buffered instruction is discarded.
- Instruction memory shares `rst_n` and must drop any in-flight response on reset.

## Timing
- `imem_req_valid`, `inst_valid` and `fault` are Moore outputs, registered off state.
- First request: `imem_req_valid` rises after the first rising edge following `rst_n` deassertion (BOOT->REQ).
- Request handshake: the request completes on an edge where `imem_req_valid`&`imem_req_ready`. The address is held until then.
- Response latency: a response may arrive in the first WAIT cycle or any later one.
- `inst_valid` rises on the edge after `imem_resp_valid`.
- Retire edge: HOLD->REQ. The new address appears in the following cycle.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD, each with zero wait states).
- `jump`, `pcsrc`, `jump_target` and `branch_target` are don't-care outside HOLD&`inst_ready`.

## Test plan
- Reset and sequential fetch, zero-wait memory with `inst_ready` tied 1:
  - requests go to 8000_0000, 8000_0004, 8000_0008.
  - `inst_valid` pulses every 3rd cycle with the matching `inst_pc`.
- Backpressure: `imem_req_ready` low for 4 cycles, response delayed 3 cycles, `inst_ready` low for 5 cycles:
  - address, `inst` and `inst_pc` stay stable throughout.
  - no second request is issued before retire.
- Branch/jump priority:
  - retire with `pcsrc`=1, `branch_target`=8000_0100 -> next request 8000_0100.
  - `jump`=1 and `pcsrc`=1, `jump_target`=8000_0200 -> next request 8000_0200.
- Decode slices: response 0x0128_2020 -> `op`=6'h00, `funct`=6'h20; response 0x8C43_0004 -> `op`=6'h23.
- Misalignment and wrap:
  - `jump_target`=8000_0102 -> `fault`=1, `imem_req_valid` stays 0 until reset.
  - with RESET_PC=FFFF_FFFC, retire with no branch or jump -> next request 0000_0000.
- Reset mid-WAIT:
  - drop `rst_n` for 1 cycle while a response is pending -> outputs at reset values immediately.
  - next request goes to RESET_PC.
  - a stale response in REQ is ignored.
